riscvssc_mem_responder: RTL and testbench

Single-port memory responder that terminates one `vc` memory request/response channel driven by the 7-stage RISCV core: instruction port 0, instruction port 1 or the data port, one instance per port. Accepts packed request messages under val/rdy and performs byte-granular reads and writes on an internal byte array. Returns packed response messages in request order after a fixed, parameterised latency, with bounded buffering and backpressure. Serves as the simulation memory for the core test harness.

---
 rtl/riscvssc_mem_responder.sv | 144 ++++++++++++++
 tb/tb_riscvssc_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscvssc_mem_responder.sv
// Byte-addressed simulation memory behind one val/rdy request/response channel.
// Optional random stall injection is compiled in with `define RISCV_MEM_RESP_STALL_EN.
module riscvssc_mem_responder #(
    parameter int ADDR_BITS = 16,
    parameter int LATENCY   = 2,
    parameter int DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [66:0] memreq_msg,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    output logic [34:0] memresp_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy
);

    localparam int MEM_BYTES = 1 << ADDR_BITS;
    localparam int PW        = $clog2(DEPTH);
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int DL        = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic [7:0]           mem [MEM_BYTES];
    logic                 req_go;
    logic                 resp_go;
    logic                 stall_req;
    logic                 stall_resp;

    logic                 req_type;
    logic [ADDR_BITS-1:0] req_addr;
    logic [1:0]           req_len;
    logic [31:0]          req_data;
    logic [2:0]           byte_cnt;
    logic [ADDR_BITS-1:0] byte_addr [4];
    logic [3:0]           byte_en;
    logic [3:0]           wr_en;
    logic [31:0]          rd_data;
    logic [34:0]          resp_new;
    logic                 exit_val;
    logic [34:0]          exit_msg;
    logic                 unused_addr_hi;

    logic [34:0]          fifo_mem [DEPTH];
    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic [CW-1:0]        outstanding_reg;
    logic                 rdy_en_reg;

`ifdef RISCV_MEM_RESP_STALL_EN
    logic [15:0]          lfsr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign stall_req  = (lfsr_reg[1:0] == 2'b00);
    assign stall_resp = (lfsr_reg[3:2] == 2'b00);
`else
    assign stall_req  = 1'b0;
    assign stall_resp = 1'b0;
`endif

    assign req_type       = memreq_msg[66];
    assign req_addr       = memreq_msg[34 +: ADDR_BITS];
    assign req_len        = memreq_msg[33:32];
    assign req_data       = memreq_msg[31:0];
    assign byte_cnt       = (req_len == 2'd0) ? 3'd4 : {1'b0, req_len};
    assign unused_addr_hi = ^memreq_msg[65:34];

    // Each lane addresses its own byte; the adder wraps at the top of memory.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_addr[gi]       = req_addr + ADDR_BITS'(gi);
        assign byte_en[gi]         = (3'(gi) < byte_cnt);
        assign rd_data[8*gi +: 8]  = byte_en[gi] ? mem[byte_addr[gi]] : 8'h00;
    end

    assign wr_en    = {4{req_go & req_type}} & byte_en;
    assign resp_new = {req_type, req_len, req_type ? 32'h0 : rd_data};

    always_ff @(posedge clk) begin
        if (wr_en[0]) mem[byte_addr[0]] <= req_data[7:0];
        if (wr_en[1]) mem[byte_addr[1]] <= req_data[15:8];
        if (wr_en[2]) mem[byte_addr[2]] <= req_data[23:16];
        if (wr_en[3]) mem[byte_addr[3]] <= req_data[31:24];
    end

    // The accept edge counts as the first latency cycle, so only LATENCY-1 registers follow it.
    if (LATENCY == 1) begin : g_no_dl
        assign exit_val = req_go;
        assign exit_msg = resp_new;
    end else begin : g_dl
        logic [DL-1:0]       dl_val_reg;
        logic [DL-1:0][34:0] dl_msg_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dl_val_reg <= '0;
            end else begin
                dl_val_reg <= (dl_val_reg << 1) | DL'(req_go);
            end
        end

        always_ff @(posedge clk) begin
            dl_msg_reg <= (dl_msg_reg << 35) | (DL*35)'(resp_new);
        end

        assign exit_val = dl_val_reg[DL-1];
        assign exit_msg = dl_msg_reg[DL-1];
    end

    always_ff @(posedge clk) begin
        if (exit_val) fifo_mem[wr_ptr_reg] <= exit_msg;
    end

    // Credits cover both the delay line and the FIFO, so the FIFO cannot overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            outstanding_reg <= '0;
            rdy_en_reg      <= 1'b0;
        end else begin
            rdy_en_reg      <= 1'b1;
            if (exit_val) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (resp_go)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg       <= count_reg + CW'(exit_val) - CW'(resp_go);
            outstanding_reg <= outstanding_reg + CW'(req_go) - CW'(resp_go);
        end
    end

    assign memreq_rdy  = rdy_en_reg && (outstanding_reg < CW'(DEPTH)) && !stall_req;
    assign req_go      = memreq_val && memreq_rdy;
    assign memresp_val = (count_reg != '0) && !stall_resp;
    assign memresp_msg = (count_reg != '0) ? fifo_mem[rd_ptr_reg] : 35'h0;
    assign resp_go     = memresp_val && memresp_rdy;

endmodule

// File: tb/tb_riscvssc_mem_responder.sv
// Randomized bench for riscvssc_mem_responder: byte-array reference model plus
// an in-order expected-response queue with earliest-valid timing per entry.
module tb_riscvssc_mem_responder;

    localparam int ADDR_BITS = 16;
    localparam int LATENCY   = 2;
    localparam int DEPTH     = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [66:0] memreq_msg = '0;
    logic        memreq_val = 1'b0;
    logic        memreq_rdy;
    logic [34:0] memresp_msg;
    logic        memresp_val;
    logic        memresp_rdy;

    riscvssc_mem_responder #(
        .ADDR_BITS (ADDR_BITS),
        .LATENCY   (LATENCY),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [34:0] msg;
        int          acc_c;
    } txn_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          out_m = 0;
    int          last_pop_c = 0;
    int          rdy_mode = 1;
    bit          mon_en = 1'b0;
    txn_t        exp_q[$];
    logic [34:0] rx_q[$];
    logic [7:0]  model_mem [65536];

    int          mon_exp_c;
    logic        mon_exp_val;
    logic [15:0] mon_a;
    logic [1:0]  mon_len;
    int          mon_n;
    logic [31:0] mon_d;
    logic [31:0] mon_rd;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] mk(logic t, logic [1:0] len, logic [31:0] d);
        return {t, len, d};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Only writer of memresp_rdy: 0 = hold low, 1 = hold high, 2 = random.
    initial begin
        memresp_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       memresp_rdy = 1'b0;
                1:       memresp_rdy = 1'b1;
                default: memresp_rdy = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: handshakes sampled mid-cycle take effect at the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            out_m      = 0;
            last_pop_c = cyc;
        end else if (mon_en) begin
            mon_exp_val = 1'b0;
            if (exp_q.size() != 0) begin
                mon_exp_c = exp_q[0].acc_c + LATENCY;
                if (last_pop_c + 1 > mon_exp_c) mon_exp_c = last_pop_c + 1;
                mon_exp_val = (cyc >= mon_exp_c);
            end
`ifdef RISCV_MEM_RESP_STALL_EN
            if (memresp_val) check("resp_val", memresp_val, mon_exp_val);
            if (memreq_rdy)  check("req_rdy", memreq_rdy, out_m < DEPTH);
`else
            check("resp_val", memresp_val, mon_exp_val);
            check("req_rdy", memreq_rdy, out_m < DEPTH);
`endif
            if (memresp_val && exp_q.size() != 0) begin
                check("resp_msg", memresp_msg, exp_q[0].msg);
                if (memresp_rdy) begin
                    rx_q.push_back(memresp_msg);
                    void'(exp_q.pop_front());
                    out_m--;
                    last_pop_c = cyc;
                end
            end
            if (memreq_val && memreq_rdy) begin
                mon_a   = memreq_msg[49:34];
                mon_len = memreq_msg[33:32];
                mon_d   = memreq_msg[31:0];
                mon_n   = (mon_len == 2'd0) ? 4 : int'(mon_len);
                mon_rd  = '0;
                for (int k = 0; k < mon_n; k++) begin
                    if (memreq_msg[66]) model_mem[16'(mon_a + 16'(k))] = mon_d[8*k +: 8];
                    else                mon_rd[8*k +: 8] = model_mem[16'(mon_a + 16'(k))];
                end
                exp_q.push_back('{msg: memreq_msg[66] ? mk(1'b1, mon_len, 32'h0)
                                                      : mk(1'b0, mon_len, mon_rd),
                                  acc_c: cyc});
                out_m++;
            end
        end
    end

    task automatic send(logic t, logic [15:0] a, logic [1:0] len, logic [31:0] d);
        int n;
        memreq_msg = {t, 16'($urandom), a, len, d};
        memreq_val = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!memreq_rdy && n < 500);
        if (!memreq_rdy) check("send_timeout", memreq_rdy, 1);
        @(posedge clk);
        #1;
        memreq_val = 1'b0;
    endtask

    task automatic wait_rx(int n);
        int k;
        k = 0;
        while (rx_q.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (rx_q.size() < n) check("rx_timeout", rx_q.size(), n);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic reset_pulse();
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("rst_val", memresp_val, 0);
        check("rst_rdy", memreq_rdy, 0);
        check("rst_msg", memresp_msg, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rel_rdy0", memreq_rdy, 0);
        @(posedge clk);
        #1;
        check("rel_rdy1", memreq_rdy, 1);
        check("rel_val", memresp_val, 0);
        mon_en = 1'b1;
    endtask

    initial begin
        int          base;
        logic [34:0] hold;
        logic [15:0] ra;

        #1;
        reset_pulse();

        // Directed: basic read, read-after-write, partial read, wrap-around read.
        base = rx_q.size();
        send(1'b1, 16'h0100, 2'd0, 32'hDEADBEEF);
        send(1'b0, 16'h0100, 2'd0, 32'h0);
        send(1'b1, 16'h0103, 2'd1, 32'h00000055);
        send(1'b0, 16'h0100, 2'd0, 32'h0);
        send(1'b0, 16'h0101, 2'd2, 32'h0);
        send(1'b1, 16'hFFFC, 2'd0, 32'h11223344);
        send(1'b1, 16'h0000, 2'd0, 32'h88776655);
        send(1'b0, 16'hFFFE, 2'd0, 32'h0);
        wait_rx(base + 8);
        if (rx_q.size() >= base + 8) begin
            check("wr_resp",   rx_q[base+0], mk(1'b1, 2'd0, 32'h0));
            check("rd_word",   rx_q[base+1], mk(1'b0, 2'd0, 32'hDEADBEEF));
            check("wr1_resp",  rx_q[base+2], mk(1'b1, 2'd1, 32'h0));
            check("raw_word",  rx_q[base+3], mk(1'b0, 2'd0, 32'h55ADBEEF));
            check("rd_half",   rx_q[base+4], mk(1'b0, 2'd2, 32'h0000ADBE));
            check("rd_wrap",   rx_q[base+7], mk(1'b0, 2'd0, 32'h66551122));
        end
        wait_idle();

        // Backpressure: fill all credits, head must hold, ready returns after the first pop.
        rdy_mode = 0;
        @(posedge clk);
        #2;
        base = rx_q.size();
        for (int i = 0; i < 4; i++) send(1'b0, 16'h0100, 2'd0, 32'h0);
        fork
            send(1'b0, 16'h0100, 2'd0, 32'h0);
            begin
                repeat (4) @(negedge clk);
                check("full_rdy", memreq_rdy, 0);
                hold = memresp_msg;
                check("full_head", hold, mk(1'b0, 2'd0, 32'h55ADBEEF));
                repeat (3) @(negedge clk);
                check("hold_msg", memresp_msg, hold);
                rdy_mode = 1;
            end
        join
        wait_rx(base + 5);
        wait_idle();

        // Back-to-back reads: the monitor's timing check forbids bubbles.
        for (int i = 0; i < 8; i++) send(1'b0, 16'h0100, 2'(i), 32'h0);
        wait_idle();

        // Reset with three responses in flight.
        rdy_mode = 0;
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) send(1'b0, 16'h0100, 2'd0, 32'h0);
        rdy_mode = 1;
        reset_pulse();
        repeat (6) @(posedge clk);
        #1;
        base = rx_q.size();
        send(1'b0, 16'h0100, 2'd0, 32'h0);
        wait_rx(base + 1);
        if (rx_q.size() >= base + 1) check("persist", rx_q[base], mk(1'b0, 2'd0, 32'h55ADBEEF));
        wait_idle();

        // Preload the two random-traffic windows (0xFFC0..0x003F wraps, 0x0100..0x013F).
        for (int i = 0; i < 32; i++) send(1'b1, 16'hFFC0 + 16'(4*i), 2'd0, $urandom);
        for (int i = 0; i < 16; i++) send(1'b1, 16'h0100 + 16'(4*i), 2'd0, $urandom);

        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) ra = 16'hFFC0 + 16'($urandom_range(0, 124));
            else                           ra = 16'h0100 + 16'($urandom_range(0, 60));
            send(($urandom_range(0, 2) == 0), ra, 2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
